// File: rtl/alu_arbiter_if.sv
// Signal bundle between two requesters, the alu_arbiter and the shared ALU.
// slave modport is the arbiter's view; master is the requester/ALU environment.
interface alu_arbiter_if #(
    parameter int DATA_W = 32
);
  logic              req0_valid, req1_valid;
  logic              req0_ready, req1_ready;
  logic [2:0]        req0_aluop, req1_aluop;
  logic [2:0]        req0_func3, req1_func3;
  logic [6:0]        req0_func7, req1_func7;
  logic [6:0]        req0_opcode, req1_opcode;
  logic [DATA_W-1:0] req0_a, req1_a;
  logic [DATA_W-1:0] req0_b, req1_b;
  logic              rsp0_valid, rsp1_valid;
  logic [DATA_W-1:0] rsp0_result, rsp1_result;
  logic [2:0]        alu_aluop;
  logic [2:0]        alu_func3;
  logic [6:0]        alu_func7;
  logic [6:0]        alu_opcode;
  logic [DATA_W-1:0] alu_a, alu_b;
  logic [DATA_W-1:0] alu_result;
  logic              busy;

  modport slave (
    input  req0_valid, req1_valid, req0_aluop, req1_aluop, req0_func3, req1_func3,
           req0_func7, req1_func7, req0_opcode, req1_opcode, req0_a, req1_a,
           req0_b, req1_b, alu_result,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_result, rsp1_result,
           alu_aluop, alu_func3, alu_func7, alu_opcode, alu_a, alu_b, busy
  );

  modport master (
    output req0_valid, req1_valid, req0_aluop, req1_aluop, req0_func3, req1_func3,
           req0_func7, req1_func7, req0_opcode, req1_opcode, req0_a, req1_a,
           req0_b, req1_b, alu_result,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_result, rsp1_result,
           alu_aluop, alu_func3, alu_func7, alu_opcode, alu_a, alu_b, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters (round-robin; ALU_ARB_FIXED_PRIO_EN gives req0 fixed priority).
// Accept -> rsp pulse 2 cycles later, one op per 3 cycles; ready only offered in IDLE.
module alu_arbiter #(
    parameter int DATA_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t            state_q, state_d;
  logic              id_q, id_d;
  logic [2:0]        aluop_q, aluop_d;
  logic [2:0]        func3_q, func3_d;
  logic [6:0]        func7_q, func7_d;
  logic [6:0]        opcode_q, opcode_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              rsp0_vld_q, rsp0_vld_d;
  logic              rsp1_vld_q, rsp1_vld_d;
  logic              busy_q, busy_d;
  logic              gnt0, gnt1;

`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb begin
    gnt0 = bus.req0_valid;
    gnt1 = bus.req1_valid & ~bus.req0_valid;
  end
`else
  // last_q == 1 means requester 1 was granted last, so requester 0 wins a tie.
  logic last_q, last_d;

  always_comb begin
    gnt0 = bus.req0_valid & (~bus.req1_valid | last_q);
    gnt1 = bus.req1_valid & (~bus.req0_valid | ~last_q);
  end
`endif

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    aluop_d    = aluop_q;
    func3_d    = func3_q;
    func7_d    = func7_q;
    opcode_d   = opcode_q;
    a_d        = a_q;
    b_d        = b_q;
    result_d   = result_q;
    rsp0_vld_d = 1'b0;
    rsp1_vld_d = 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
    last_d     = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (gnt0 || gnt1) begin
          state_d  = ISSUE;
          id_d     = gnt1;
          aluop_d  = gnt1 ? bus.req1_aluop  : bus.req0_aluop;
          func3_d  = gnt1 ? bus.req1_func3  : bus.req0_func3;
          func7_d  = gnt1 ? bus.req1_func7  : bus.req0_func7;
          opcode_d = gnt1 ? bus.req1_opcode : bus.req0_opcode;
          a_d      = gnt1 ? bus.req1_a      : bus.req0_a;
          b_d      = gnt1 ? bus.req1_b      : bus.req0_b;
`ifndef ALU_ARB_FIXED_PRIO_EN
          last_d   = gnt1;
`endif
        end
      end
      ISSUE: begin
        state_d    = RESP;
        result_d   = bus.alu_result;
        rsp0_vld_d = ~id_q;
        rsp1_vld_d = id_q;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      id_q       <= 1'b0;
      aluop_q    <= '0;
      func3_q    <= '0;
      func7_q    <= '0;
      opcode_q   <= '0;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      rsp0_vld_q <= 1'b0;
      rsp1_vld_q <= 1'b0;
      busy_q     <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_q     <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      aluop_q    <= aluop_d;
      func3_q    <= func3_d;
      func7_q    <= func7_d;
      opcode_q   <= opcode_d;
      a_q        <= a_d;
      b_q        <= b_d;
      result_q   <= result_d;
      rsp0_vld_q <= rsp0_vld_d;
      rsp1_vld_q <= rsp1_vld_d;
      busy_q     <= busy_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_q     <= last_d;
`endif
    end
  end

  assign bus.req0_ready  = (state_q == IDLE) & gnt0;
  assign bus.req1_ready  = (state_q == IDLE) & gnt1;
  assign bus.rsp0_valid  = rsp0_vld_q;
  assign bus.rsp1_valid  = rsp1_vld_q;
  assign bus.rsp0_result = result_q;
  assign bus.rsp1_result = result_q;
  assign bus.alu_aluop   = aluop_q;
  assign bus.alu_func3   = func3_q;
  assign bus.alu_func7   = func7_q;
  assign bus.alu_opcode  = opcode_q;
  assign bus.alu_a       = a_q;
  assign bus.alu_b       = b_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized scoreboard bench for alu_arbiter with a behavioural arbitration and ALU model.
module tb_alu_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_arbiter_if #(.DATA_W(32)) ifc ();
  alu_arbiter #(.DATA_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

  typedef struct {
    int          id;
    logic [2:0]  aluop, f3;
    logic [6:0]  f7, opc;
    logic [31:0] a, b, res;
    int          due;
  } op_t;

  op_t  sb[$];
  int   glog[$];
  int   clog[$];
  op_t  cur;
  bit   have_cur;
  int   free_at;
  int   last_gnt;
  logic [31:0] last_res;
  bit   acc0, acc1;

  // Behavioural shared ALU: aluop 2 decodes R-type func3/func7.
  function automatic logic [31:0] alu_fn(logic [2:0] op, logic [2:0] f3, logic [6:0] f7,
                                         logic [6:0] opc, logic [31:0] a, logic [31:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: begin
        case (f3)
          3'd0:    return f7[5] ? a - b : a + b;
          3'd1:    return a << b[4:0];
          3'd4:    return a ^ b;
          3'd6:    return a | b;
          3'd7:    return a & b;
          default: return a + b + {25'd0, opc};
        endcase
      end
      default: return a ^ b ^ {25'd0, opc};
    endcase
  endfunction

  assign ifc.alu_result = alu_fn(ifc.alu_aluop, ifc.alu_func3, ifc.alu_func7,
                                 ifc.alu_opcode, ifc.alu_a, ifc.alu_b);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic op_t snap(int n);
    op_t o;
    o.id = n;
    if (n == 0) begin
      o.aluop = ifc.req0_aluop; o.f3 = ifc.req0_func3; o.f7 = ifc.req0_func7;
      o.opc = ifc.req0_opcode;  o.a = ifc.req0_a;      o.b = ifc.req0_b;
    end else begin
      o.aluop = ifc.req1_aluop; o.f3 = ifc.req1_func3; o.f7 = ifc.req1_func7;
      o.opc = ifc.req1_opcode;  o.a = ifc.req1_a;      o.b = ifc.req1_b;
    end
    o.res = alu_fn(o.aluop, o.f3, o.f7, o.opc, o.a, o.b);
    o.due = 0;
    return o;
  endfunction

  task automatic set_op(input int n, input logic [2:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [6:0] opc,
                        input logic [31:0] a, input logic [31:0] b);
    if (n == 0) begin
      ifc.req0_aluop = op; ifc.req0_func3 = f3; ifc.req0_func7 = f7;
      ifc.req0_opcode = opc; ifc.req0_a = a; ifc.req0_b = b;
    end else begin
      ifc.req1_aluop = op; ifc.req1_func3 = f3; ifc.req1_func7 = f7;
      ifc.req1_opcode = opc; ifc.req1_a = a; ifc.req1_b = b;
    end
  endtask

  task automatic set_valid(input int n, input logic v);
    if (n == 0) ifc.req0_valid = v;
    else        ifc.req1_valid = v;
  endtask

  task automatic rand_op(input int n);
    logic [31:0] a;
    a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom();
    set_op(n, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, 7'($urandom()), a, $urandom());
  endtask

  // Per-cycle model: the arbiter may only accept when the previous op's 3-cycle slot is over.
  task automatic check_cycle();
    bit idle, v0, v1, e0, e1;
    op_t o;
    idle = (cyc >= free_at);
    v0 = ifc.req0_valid;
    v1 = ifc.req1_valid;
    e0 = 1'b0;
    e1 = 1'b0;
    if (idle) begin
      if (v0 && v1) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        e0 = 1'b1;
`else
        if (last_gnt == 1) e0 = 1'b1;
        else               e1 = 1'b1;
`endif
      end else if (v0) e0 = 1'b1;
      else if (v1)     e1 = 1'b1;
    end
    chk("busy", ifc.busy, !idle);
    chk("req0_ready", ifc.req0_ready, e0);
    chk("req1_ready", ifc.req1_ready, e1);
    if (have_cur) begin
      chk("alu_a", ifc.alu_a, cur.a);
      chk("alu_b", ifc.alu_b, cur.b);
      if (!idle && cyc == free_at - 2)
        chk("alu_ctrl", {ifc.alu_aluop, ifc.alu_func3, ifc.alu_func7, ifc.alu_opcode},
            {cur.aluop, cur.f3, cur.f7, cur.opc});
    end
    if (!ifc.rsp0_valid && !ifc.rsp1_valid) begin
      chk("rsp0_hold", ifc.rsp0_result, last_res);
      chk("rsp1_hold", ifc.rsp1_result, last_res);
    end
    if (sb.size() > 0 && sb[0].due < cyc) begin
      checks++;
      errors++;
      $display("FAIL rsp_missing at cycle %0d: no pulse for id %0d due %0d", cyc, sb[0].id, sb[0].due);
      void'(sb.pop_front());
    end
    acc0 = v0 && ifc.req0_ready;
    acc1 = v1 && ifc.req1_ready;
    if (e0 || e1) begin
      o = snap(e1 ? 1 : 0);
      o.due = cyc + 2;
      sb.push_back(o);
      cur = o;
      have_cur = 1'b1;
      free_at = cyc + 3;
      last_gnt = o.id;
      glog.push_back(o.id);
      clog.push_back(cyc);
    end
  endtask

  always @(negedge clk) begin
    op_t e;
    if (rst_n && (ifc.rsp0_valid || ifc.rsp1_valid)) begin
      chk("rsp_onehot", {31'd0, ifc.rsp0_valid & ifc.rsp1_valid}, 32'd0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected at cycle %0d: rsp0=%b rsp1=%b", cyc, ifc.rsp0_valid, ifc.rsp1_valid);
      end else begin
        e = sb.pop_front();
        chk("rsp_id", {31'd0, ifc.rsp1_valid}, e.id);
        chk("rsp_result", ifc.rsp1_valid ? ifc.rsp1_result : ifc.rsp0_result, e.res);
        chk("rsp_latency", cyc, e.due);
        last_res = e.res;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ifc.req0_valid = 1'b0;
    ifc.req1_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_busy", ifc.busy, 0);
    chk("rst_alu_a", ifc.alu_a, 0);
    chk("rst_alu_ctrl", {ifc.alu_aluop, ifc.alu_func3, ifc.alu_func7, ifc.alu_opcode}, 0);
    chk("rst_rsp_valid", {ifc.rsp0_valid, ifc.rsp1_valid}, 0);
    chk("rst_result", ifc.rsp0_result, 0);
    sb.delete();
    free_at = 0;
    last_gnt = 1;
    last_res = '0;
    have_cur = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int n_ok;
    rst_n = 1'b1;
    ifc.req0_valid = 1'b0;
    ifc.req1_valid = 1'b0;
    set_op(0, 0, 0, 0, 0, 0, 0);
    set_op(1, 0, 0, 0, 0, 0, 0);
    #2;
    do_reset();

    // Single subtract from req0: 10 - 3 = 7 two cycles after accept.
    set_op(0, 3'd2, 3'd0, 7'h20, 7'h33, 32'd10, 32'd3);
    ifc.req0_valid = 1'b1;
    step();
    ifc.req0_valid = 1'b0;
    repeat (4) step();

    // Continuous contention straight out of reset.
    do_reset();
    glog.delete();
    clog.delete();
    rand_op(0);
    rand_op(1);
    ifc.req0_valid = 1'b1;
    ifc.req1_valid = 1'b1;
    for (int k = 0; k < 20 && glog.size() < 4; k++) begin
      step();
      if (acc0) rand_op(0);
      if (acc1) rand_op(1);
    end
    chk("contention_ops", glog.size(), 4);
    n_ok = (glog.size() < 4) ? glog.size() : 4;
    for (int k = 0; k < n_ok; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      chk("grant_order", glog[k], 0);
`else
      chk("grant_order", glog[k], k % 2);
`endif
      if (k > 0) chk("accept_gap", clog[k] - clog[k-1], 3);
    end
    ifc.req0_valid = 1'b0;
    ifc.req1_valid = 1'b0;
    repeat (4) step();

    // req1 arrives while a req0 op is in ISSUE.
    rand_op(0);
    ifc.req0_valid = 1'b1;
    step();
    ifc.req0_valid = 1'b0;
    rand_op(1);
    ifc.req1_valid = 1'b1;
    for (int k = 0; k < 6 && !acc1; k++) step();
    chk("late_req1_accepted", acc1, 1);
    ifc.req1_valid = 1'b0;
    repeat (4) step();

    // Reset during ISSUE of a req1 op discards it.
    set_op(1, 3'd0, 3'd0, 7'h00, 7'h33, 32'hFFFF_FFFF, 32'd5);
    ifc.req1_valid = 1'b1;
    step();
    chk("rst_case_accept", acc1, 1);
    ifc.req1_valid = 1'b0;
    @(negedge clk);
    check_cycle();
    do_reset();
    chk("post_rst_alu_a", ifc.alu_a, 0);
    chk("post_rst_busy", ifc.busy, 0);
    repeat (4) step();
    rand_op(0);
    rand_op(1);
    glog.delete();
    ifc.req0_valid = 1'b1;
    ifc.req1_valid = 1'b1;
    step();
    chk("post_rst_grant", (glog.size() > 0) ? glog[0] : -1, 0);
    ifc.req0_valid = 1'b0;
    ifc.req1_valid = 1'b0;
    repeat (4) step();

    // Random traffic, including the occasional withdrawn request.
    for (int i = 0; i < 600; i++) begin
      step();
      for (int n = 0; n < 2; n++) begin
        bit v, acc;
        v   = (n == 0) ? ifc.req0_valid : ifc.req1_valid;
        acc = (n == 0) ? acc0 : acc1;
        if (acc) begin
          if ($urandom_range(0, 3) != 0) rand_op(n);
          else set_valid(n, 1'b0);
        end else if (v) begin
          if ($urandom_range(0, 15) == 0) set_valid(n, 1'b0);
        end else if ($urandom_range(0, 1) == 0) begin
          rand_op(n);
          set_valid(n, 1'b1);
        end
      end
    end
    ifc.req0_valid = 1'b0;
    ifc.req1_valid = 1'b0;
    repeat (6) step();
    chk("scoreboard_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
